// File: rtl/sfr_bridge.sv
// rtl/sfr_bridge.sv - b16 data-port bridge to SFR bus and memory port; BRIDGE_TIMEOUT_EN adds a memory timeout
module sfr_bridge #(
    parameter logic [7:0] SFR_BASE = 8'hFF,
    parameter int         WAIT     = 1,
    parameter int         TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r,
    input  logic [1:0]  cpu_w,
    input  logic [15:0] cpu_dwrite,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        sfr_sel,
    output logic [7:0]  sfr_addr,
    output logic        sfr_r,
    output logic [1:0]  sfr_w,
    output logic [15:0] sfr_dwrite,
    input  logic [15:0] sfr_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic        mem_r,
    output logic [1:0]  mem_w,
    output logic [15:0] mem_dwrite,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SFR, MEM, ACK} state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    generate
        if (WAIT < 0 || WAIT > 15 || TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_param
            $error("sfr_bridge: parameter out of range");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        r_q, r_d;
    logic [1:0]  w_q, w_d;
    logic [15:0] dwrite_q, dwrite_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_C = 16'(TIMEOUT);
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            r_q      <= 1'b0;
            w_q      <= '0;
            dwrite_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            r_q      <= r_d;
            w_q      <= w_d;
            dwrite_q <= dwrite_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        r_d      = r_q;
        w_d      = w_q;
        dwrite_d = dwrite_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
`ifdef BRIDGE_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d   = cpu_addr;
                    r_d      = cpu_r;
                    w_d      = cpu_w;
                    dwrite_d = cpu_dwrite;
                    if (cpu_addr[15:8] == SFR_BASE) begin
                        state_d = SFR;
                        cnt_d   = WAIT_C;
                    end else begin
                        state_d = MEM;
`ifdef BRIDGE_TIMEOUT_EN
                        tmo_d   = TMO_C;
`endif
                    end
                end
            end
            SFR: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = r_q ? sfr_data : 16'h0000;
                    state_d = ACK;
                end
            end
            MEM: begin
                // A mem_ack arriving on the expiry cycle still returns real data.
                if (mem_ack) begin
                    rdata_d = r_q ? mem_rdata : 16'h0000;
                    state_d = ACK;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (tmo_q <= 16'd1) begin
                    rdata_d = 16'hDEAD;
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Write enables only in the first SFR cycle so the SFR block sees one write edge.
    assign sfr_sel    = (state_q == SFR);
    assign sfr_addr   = addr_q[7:0];
    assign sfr_r      = sfr_sel & r_q;
    assign sfr_w      = (sfr_sel && cnt_q == WAIT_C) ? w_q : 2'b00;
    assign sfr_dwrite = dwrite_q;

    assign mem_req    = (state_q == MEM);
    assign mem_addr   = addr_q;
    assign mem_r      = mem_req & r_q;
    assign mem_w      = mem_req ? w_q : 2'b00;
    assign mem_dwrite = dwrite_q;

    assign cpu_ack    = (state_q == ACK);
    assign cpu_rdata  = rdata_q;
`ifdef BRIDGE_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_bridge.sv
// tb/tb_sfr_bridge.sv - randomized bench for sfr_bridge with a per-cycle expected-output timeline
module tb_sfr_bridge;
    localparam int WAIT = 1;
`ifdef BRIDGE_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_r = 1'b0;
    logic [1:0]  cpu_w = '0;
    logic [15:0] cpu_dwrite = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        sfr_sel;
    logic [7:0]  sfr_addr;
    logic        sfr_r;
    logic [1:0]  sfr_w;
    logic [15:0] sfr_dwrite;
    logic [15:0] sfr_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_r;
    logic [1:0]  mem_w;
    logic [15:0] mem_dwrite;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;

    sfr_bridge #(.SFR_BASE(8'hFF), .WAIT(WAIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .nreset(nreset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_w(cpu_w),
        .cpu_dwrite(cpu_dwrite), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .sfr_sel(sfr_sel), .sfr_addr(sfr_addr), .sfr_r(sfr_r), .sfr_w(sfr_w),
        .sfr_dwrite(sfr_dwrite), .sfr_data(sfr_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w),
        .mem_dwrite(mem_dwrite), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ack;
        bit        sel;
        bit        sr;
        bit [1:0]  sw;
        bit [7:0]  sa;
        bit [15:0] sd;
        bit        mreq;
        bit        mr;
        bit [1:0]  mw;
        bit [15:0] ma;
        bit [15:0] md;
        bit [15:0] rdata;
        bit        err;
    } rec_t;

    rec_t        expq[$];
    logic [15:0] exp_rdata = '0;
    bit          exp_err = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          sel_cycles, mreq_cycles, w_cycles;
    logic [15:0] periph[256];
    logic [15:0] mreg[256];

    assign sfr_data = periph[sfr_addr];

    // SFR block: byte writes land on the falling edge.
    always @(negedge clk) begin
        if (nreset && sfr_sel) begin
            if (sfr_w[0]) periph[sfr_addr][7:0]  = sfr_dwrite[7:0];
            if (sfr_w[1]) periph[sfr_addr][15:8] = sfr_dwrite[15:8];
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (!nreset) begin
            chk("rst_ack", cpu_ack, 0);   chk("rst_rdata", cpu_rdata, 0);
            chk("rst_sel", sfr_sel, 0);   chk("rst_saddr", sfr_addr, 0);
            chk("rst_sr", sfr_r, 0);      chk("rst_sw", sfr_w, 0);
            chk("rst_sdw", sfr_dwrite, 0); chk("rst_mreq", mem_req, 0);
            chk("rst_maddr", mem_addr, 0); chk("rst_mr", mem_r, 0);
            chk("rst_mw", mem_w, 0);      chk("rst_mdw", mem_dwrite, 0);
            chk("rst_err", err, 0);
        end else begin
            e = '{default: 0};
            if (expq.size() > 0) e = expq.pop_front();
            if (e.ack) begin
                exp_rdata = e.rdata;
                exp_err   = exp_err | e.err;
            end
            chk("ack", cpu_ack, e.ack);
            chk("sfr_sel", sfr_sel, e.sel);
            chk("sfr_r", sfr_r, e.sr);
            chk("sfr_w", sfr_w, e.sw);
            chk("mem_req", mem_req, e.mreq);
            chk("mem_r", mem_r, e.mr);
            chk("mem_w", mem_w, e.mw);
            chk("rdata", cpu_rdata, exp_rdata);
            chk("err", err, exp_err);
            if (e.sel) begin
                chk("sfr_addr", sfr_addr, e.sa);
                chk("sfr_dwrite", sfr_dwrite, e.sd);
            end
            if (e.mreq) begin
                chk("mem_addr", mem_addr, e.ma);
                chk("mem_dwrite", mem_dwrite, e.md);
            end
        end
        if (sfr_sel) sel_cycles++;
        if (mem_req) mreq_cycles++;
        if (sfr_w != 2'b00) w_cycles++;
    end

    // Entered and left #1 after a posedge in an IDLE cycle; d = mem_ack cycle, 0 = never.
    task automatic do_tx(input bit [15:0] a, input bit r, input bit [1:0] w, input bit [15:0] dw,
                         input int gap, input int d, input bit [15:0] mval);
        rec_t rc;
        bit   is_sfr;
        int   n;
        if (gap > 0) begin
            cpu_req = 1'b0;
            repeat (gap) begin
                mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        cpu_req = 1'b1; cpu_addr = a; cpu_r = r; cpu_w = w; cpu_dwrite = dw;
        mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        sel_cycles = 0; mreq_cycles = 0; w_cycles = 0;
        is_sfr = (a[15:8] == 8'hFF);
        n = 0;
        if (is_sfr) begin
            for (int i = 0; i <= WAIT; i++) begin
                rc = '{default: 0};
                rc.sel = 1; rc.sa = a[7:0]; rc.sr = r; rc.sd = dw;
                rc.sw = (i == 0) ? w : 2'b00;
                expq.push_back(rc); n++;
            end
            if (w[0]) mreg[a[7:0]][7:0]  = dw[7:0];
            if (w[1]) mreg[a[7:0]][15:8] = dw[15:8];
            rc = '{default: 0};
            rc.ack = 1; rc.rdata = r ? mreg[a[7:0]] : 16'h0000;
            expq.push_back(rc); n++;
        end else begin
            for (int i = 0; i < ((d == 0) ? TMO : d); i++) begin
                rc = '{default: 0};
                rc.mreq = 1; rc.mr = r; rc.mw = w; rc.ma = a; rc.md = dw;
                expq.push_back(rc); n++;
            end
            rc = '{default: 0};
            rc.ack = 1;
            rc.rdata = (d == 0) ? 16'hDEAD : (r ? mval : 16'h0000);
            rc.err = (d == 0);
            expq.push_back(rc); n++;
        end
        for (int c = 1; c <= n; c++) begin
            if (!is_sfr && d != 0 && c == d) begin
                mem_ack = 1'b1; mem_rdata = mval;
            end else begin
                mem_ack = (is_sfr || c == n) ? 1'($urandom) : 1'b0;
                mem_rdata = 16'($urandom);
            end
            if (c < n) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        bit [15:0] a;
        rec_t      rc;
        for (int i = 0; i < 256; i++) begin
            periph[i] = 16'($urandom);
            mreg[i]   = periph[i];
        end
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        chk("reset_rdata", cpu_rdata, 16'h0000);
        chk("reset_ack", cpu_ack, 1'b0);

        periph[8'h14] = 16'h1234; mreg[8'h14] = 16'h1234;
        do_tx(16'hFF14, 1, 2'b00, 16'h0000, 1, 0, 16'h0);
        chk("sfr_read_sel_cycles", 16'(sel_cycles), 16'd2);
        chk("sfr_read_data", cpu_rdata, 16'h1234);

        do_tx(16'hFF00, 0, 2'b01, 16'hABCD, 1, 0, 16'h0);
        chk("sfr_write_w_cycles", 16'(w_cycles), 16'd1);
        chk("sfr_write_no_mem", 16'(mreq_cycles), 16'd0);
        chk("sfr_write_rdata", cpu_rdata, 16'h0000);
        chk("sfr_write_low_byte", periph[8'h00][7:0], 8'hCD);

        do_tx(16'h0100, 1, 2'b00, 16'h0000, 2, 3, 16'h5A5A);
        chk("mem_req_cycles", 16'(mreq_cycles), 16'd3);
        chk("mem_no_sel", 16'(sel_cycles), 16'd0);
        chk("mem_read_data", cpu_rdata, 16'h5A5A);

        do_tx(16'hFF10, 0, 2'b11, 16'hBEEF, 1, 0, 16'h0);
        do_tx(16'hFF10, 1, 2'b00, 16'h0000, 0, 0, 16'h0);
        chk("b2b_readback", cpu_rdata, 16'hBEEF);

        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 16'hFF20; cpu_r = 1'b1; cpu_w = 2'b00;
        @(posedge clk); #1;
        rc = '{default: 0};
        rc.sel = 1; rc.sa = 8'h20; rc.sr = 1;
        expq.push_back(rc);
        @(posedge clk); #1;
        nreset = 1'b0; cpu_req = 1'b0;
        expq.delete(); exp_rdata = '0; exp_err = 1'b0;
        #1;
        chk("async_rst_sel", sfr_sel, 1'b0);
        chk("async_rst_rdata", cpu_rdata, 16'h0000);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        do_tx(16'h0042, 1, 2'b00, 16'h0000, 0, 2, 16'h7777);
        chk("post_reset_read", cpu_rdata, 16'h7777);

`ifdef BRIDGE_TIMEOUT_EN
        do_tx(16'h0200, 1, 2'b00, 16'h0000, 1, 0, 16'h0);
        chk("timeout_rdata", cpu_rdata, 16'hDEAD);
        chk("timeout_err", err, 1'b1);
        do_tx(16'h0300, 1, 2'b00, 16'h0000, 0, 2, 16'h1111);
        chk("err_sticky", err, 1'b1);
        chk("after_timeout_rdata", cpu_rdata, 16'h1111);
`endif

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 1) == 1) a = {8'hFF, 8'($urandom)};
            else a = {8'($urandom_range(0, 254)), 8'($urandom)};
            do_tx(a, 1'($urandom), 2'($urandom), 16'($urandom),
                  $urandom_range(0, 2), $urandom_range(1, 4), 16'($urandom));
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sfr_bridge.md
Name: sfr_bridge

Overview:
- Bus bridge between the b16 core's data-memory port and the special-function-register block plus external/block RAM.
- Decodes each CPU access. Accesses whose upper address byte equals SFR_BASE go to the SFR bus (sel/addr/r/w/dwrite, combinational sfr_data return); all others go to the memory port via a req/ack handshake.
- Latches each request, sequences SFR wait states, registers the read data, and returns a single-cycle cpu_ack.

Parameters:
- SFR_BASE, 8'hFF, upper address byte selecting the SFR window.
- WAIT, 1, extra clk cycles the SFR access is held before read data is captured (0..15).
- TIMEOUT, 255, memory-port cycles before forced completion (used only with BRIDGE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held until cpu_ack.
- cpu_addr  in  16  byte address.
- cpu_r  in  1  read strobe.
- cpu_w  in  2  byte write enables: [1] = high byte, [0] = low byte.
- cpu_dwrite  in  16  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid while cpu_ack = 1.
- sfr_sel  out  1  SFR select.
- sfr_addr  out  8  SFR register address (latched cpu_addr[7:0]).
- sfr_r  out  1  SFR read strobe.
- sfr_w  out  2  SFR byte write enables.
- sfr_dwrite  out  16  SFR write data.
- sfr_data  in  16  SFR read data, combinational from the SFR block.
- mem_req  out  1  memory request.
- mem_addr  out  16  memory address.
- mem_r  out  1  memory read.
- mem_w  out  2  memory byte write enables.
- mem_dwrite  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (nreset low, asynchronous):
  - state = IDLE.
  - All latches, counters, cpu_ack, cpu_rdata, sfr_*, mem_* and err = 0.
  - Reset asserted mid-access aborts the access. No ack is ever issued for it.
- States: IDLE, SFR, MEM, ACK.
- IDLE:
  - On cpu_req = 1 at a posedge, latch addr/r/w/dwrite.
  - If cpu_addr[15:8] == SFR_BASE: go to SFR with cnt = WAIT. Otherwise go to MEM.
  - Requests are sampled only in IDLE.
- SFR:
  - sfr_sel = 1, with sfr_addr/sfr_r/sfr_dwrite taken from the latch.
  - sfr_w = latched w only in the first SFR cycle and 0 afterwards. This guarantees exactly one falling-edge write in the SFR block.
  - While cnt != 0: cnt decrements at each posedge.
  - At the posedge where cnt == 0: cpu_rdata <= sfr_data if latched r, else 0; go to ACK.
  - SFR access length = WAIT+1 cycles.
- MEM:
  - mem_req = 1, with mem_* taken from the latch; all sfr_* = 0.
  - On mem_ack = 1 at a posedge: cpu_rdata <= mem_rdata if r, else 0; go to ACK.
  - mem_ack outside MEM is ignored.
- ACK:
  - cpu_ack = 1 for exactly one cycle, then IDLE.
  - cpu_rdata holds its value until the next capture.
- Latency (req sampled at posedge 0):
  - SFR: ack high in cycle WAIT+2.
  - Memory: ack high in the cycle after mem_ack is sampled.
  - Back-to-back requests: a new request is sampled in the IDLE cycle that follows ACK.
- Null access (r = 0, w = 00): follows the normal path and is acknowledged with rdata = 0.
- Simultaneous r and w: both forwarded unchanged. The write happens at the first-cycle falling edge; the read value is the one present at capture.
- Outside their respective states, sfr_* and mem_* outputs are 0; address/data outputs keep their latched values but are don't-care.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter loads TIMEOUT on entry to MEM and decrements each cycle in MEM.
  - If it reaches 0 without mem_ack: cpu_rdata <= 16'hDEAD, err <= 1 (sticky until reset), go to ACK.
  - mem_ack in the same cycle as expiry wins: normal data is returned and err is unchanged.
- Not defined: no counter; MEM waits indefinitely; err is tied to 0.

Test Plan:
- WAIT=1, read 16'hFF14 with sfr_data = 16'h1234 → sfr_sel high for 2 cycles with sfr_addr = 8'h14; ack in cycle 3; cpu_rdata = 16'h1234.
- Write 16'hFF00, cpu_w = 2'b01, dwrite = 16'hABCD → sfr_w = 01 for exactly 1 cycle, then 00; ack with cpu_rdata = 0; no mem_req.
- Read 16'h0100, mem_ack returned 3 cycles later with mem_rdata = 16'h5A5A → mem_req held 3 cycles; one-cycle ack with rdata = 16'h5A5A; sfr_sel never high.
- Back-to-back SFR write 16'hFF10 then read 16'hFF10 → the second request is sampled in the IDLE cycle after ACK; the read returns the written value through sfr_data.
- nreset pulsed low during the second SFR cycle → all outputs 0 immediately; no cpu_ack; the next request completes normally.
- BRIDGE_TIMEOUT_EN, TIMEOUT=4, mem_ack never asserted → ack after 4 MEM cycles with rdata = 16'hDEAD; err = 1 and stays 1 after a later successful access.
